// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the five-stage core.
// Carries PC, instruction and NCH 32-bit data channels plus a valid bit.
// Supports stall (hold), flush (bubble insertion), sanitised bubbles on
// invalid loads, and a saturating stall-cycle counter for hazard profiling.
// All outputs are driven straight from flops.
module pipe_stage_reg #(
  parameter int unsigned NCH              = 5,
  parameter logic [31:0] RESET_PC         = 32'h0000_3000,
  parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W            = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_instr,
  input  logic [NCH*32-1:0]  in_data,
  output logic               out_valid,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  output logic [NCH*32-1:0]  out_data,
  output logic [CNT_W-1:0]   stall_count,
  input  logic               clr_count
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STALL = 2'd1,
    OP_FLUSH = 2'd2
  } op_e;

  op_e               op;
  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [NCH*32-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Resolve the per-edge operation: flush beats stall beats load.
  always_comb begin
    op = OP_LOAD;
    if (flush) begin
      op = OP_FLUSH;
    end else if (stall) begin
      op = OP_STALL;
    end
  end

  // Next contents of the slot for the selected operation.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    data_d  = data_q;
    unique case (op)
      OP_FLUSH: begin
        valid_d = 1'b0;
        pc_d    = KEEP_PC_ON_FLUSH ? in_pc : RESET_PC;
        instr_d = '0;
        data_d  = '0;
      end
      OP_STALL: begin
        valid_d = valid_q;
      end
      default: begin
        valid_d = in_valid;
        pc_d    = in_pc;
        instr_d = in_valid ? in_instr : '0;
        data_d  = in_valid ? in_data  : '0;
      end
    endcase
  end

  // Stall counter: clear wins, otherwise count stalled edges up to all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (op == OP_STALL && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Slot and counter flops with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_instr   = instr_q;
  assign out_data    = data_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: two instances with different
// parameters share stimulus and are checked every cycle against a
// behavioural model, with literal checks for the directed scenarios.
module tb_pipe_stage_reg;

  logic         clk;
  logic         reset;
  logic         stall, flush, clr_count;
  logic         in_valid;
  logic [31:0]  in_pc, in_instr;
  logic [159:0] in_data;

  // Instance A: NCH=5, KEEP_PC_ON_FLUSH=1, CNT_W=16
  logic         a_valid;
  logic [31:0]  a_pc, a_instr;
  logic [159:0] a_data;
  logic [15:0]  a_cnt;
  // Instance B: NCH=2, KEEP_PC_ON_FLUSH=0, CNT_W=2
  logic         b_valid;
  logic [31:0]  b_pc, b_instr;
  logic [63:0]  b_data;
  logic [1:0]   b_cnt;

  pipe_stage_reg #(.NCH(5), .RESET_PC(32'h0000_3000), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data),
    .out_valid(a_valid), .out_pc(a_pc), .out_instr(a_instr), .out_data(a_data),
    .stall_count(a_cnt), .clr_count(clr_count));

  pipe_stage_reg #(.NCH(2), .RESET_PC(32'h0000_3000), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_data(in_data[63:0]),
    .out_valid(b_valid), .out_pc(b_pc), .out_instr(b_instr), .out_data(b_data),
    .stall_count(b_cnt), .clr_count(clr_count));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: one record per instance, updated from the rules.
  logic         ma_valid, mb_valid;
  logic [31:0]  ma_pc, ma_instr, mb_pc, mb_instr;
  logic [159:0] ma_data;
  logic [63:0]  mb_data;
  int           ma_cnt, mb_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma_valid <= 1'b0; ma_pc <= 32'h3000; ma_instr <= 32'h0; ma_data <= '0; ma_cnt <= 0;
      mb_valid <= 1'b0; mb_pc <= 32'h3000; mb_instr <= 32'h0; mb_data <= '0; mb_cnt <= 0;
    end else begin
      if (clr_count) begin
        ma_cnt <= 0;
        mb_cnt <= 0;
      end else if (stall && !flush) begin
        ma_cnt <= (ma_cnt + 1 > 65535) ? 65535 : ma_cnt + 1;
        mb_cnt <= (mb_cnt + 1 > 3) ? 3 : mb_cnt + 1;
      end
      if (flush) begin
        ma_valid <= 1'b0; ma_instr <= 32'h0; ma_data <= '0; ma_pc <= in_pc;
        mb_valid <= 1'b0; mb_instr <= 32'h0; mb_data <= '0; mb_pc <= 32'h3000;
      end else if (!stall) begin
        ma_valid <= in_valid; ma_pc <= in_pc;
        mb_valid <= in_valid; mb_pc <= in_pc;
        ma_instr <= in_valid ? in_instr : 32'h0;
        mb_instr <= in_valid ? in_instr : 32'h0;
        ma_data  <= in_valid ? in_data : 160'h0;
        mb_data  <= in_valid ? in_data[63:0] : 64'h0;
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("A_valid", a_valid, ma_valid);
    chk("A_pc", a_pc, ma_pc);
    chk("A_instr", a_instr, ma_instr);
    chk("A_data", a_data, ma_data);
    chk("A_cnt", a_cnt, ma_cnt);
    chk("B_valid", b_valid, mb_valid);
    chk("B_pc", b_pc, mb_pc);
    chk("B_instr", b_instr, mb_instr);
    chk("B_data", b_data, mb_data);
    chk("B_cnt", b_cnt, mb_cnt);
  end

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl, input logic clr);
    in_valid = v; in_pc = pc; in_instr = ins; stall = st; flush = fl; clr_count = clr;
  endtask

  task automatic rand_data();
    for (int k = 0; k < 5; k++) in_data[32*k +: 32] = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    set_in(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    in_data = '1;
    repeat (2) @(negedge clk);
    chk("rst_pc", a_pc, 32'h3000);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_data", a_data, 160'h0);
    chk("rst_cnt", a_cnt, 16'd0);

    // First load after reset release.
    reset = 1'b0;
    set_in(1'b1, 32'h3004, 32'h2408_0005, 1'b0, 1'b0, 1'b0);
    rand_data();
    @(negedge clk);
    chk("ld1_pc", a_pc, 32'h3004);
    chk("ld1_instr", a_instr, 32'h2408_0005);
    chk("ld1_valid", a_valid, 1'b1);

    // Load then hold for three stalled edges with changing inputs.
    set_in(1'b1, 32'h3008, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
    rand_data();
    in_data[127:96] = 32'hDEAD_BEEF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
      rand_data();
      @(negedge clk);
    end
    chk("stl_pc", a_pc, 32'h3008);
    chk("stl_alu", a_data[127:96], 32'hDEAD_BEEF);
    chk("stl_cnt", a_cnt, 16'd3);
    set_in(1'b1, 32'h3010, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    rand_data();
    @(negedge clk);
    chk("unstl_pc", a_pc, 32'h3010);
    chk("unstl_instr", a_instr, 32'h1234_5678);

    // Flush together with stall.
    set_in(1'b1, 32'h300C, 32'hABCD_0001, 1'b1, 1'b1, 1'b0);
    rand_data();
    @(negedge clk);
    chk("fl_valid", a_valid, 1'b0);
    chk("fl_instr", a_instr, 32'h0);
    chk("fl_data", a_data, 160'h0);
    chk("fl_pcA", a_pc, 32'h300C);
    chk("fl_pcB", b_pc, 32'h3000);
    chk("fl_cnt", a_cnt, 16'd3);

    // Invalid load is sanitised.
    set_in(1'b0, 32'h3014, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    in_data = '1;
    @(negedge clk);
    chk("bub_valid", a_valid, 1'b0);
    chk("bub_instr", a_instr, 32'h0);
    chk("bub_data", a_data, 160'h0);
    chk("bub_pc", a_pc, 32'h3014);

    // Saturation of the 2-bit counter, then clear beating stall.
    set_in(1'b1, 32'h3018, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, $urandom, $urandom, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("sat_cnt", b_cnt, (i < 3) ? i + 1 : 3);
    end
    set_in(1'b1, 32'h301C, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_cnt", b_cnt, 2'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom % 2), $urandom, $urandom, 1'(($urandom % 10) < 3),
             1'(($urandom % 10) == 0), 1'(($urandom % 20) == 0));
      rand_data();
      @(negedge clk);
    end

    // Asynchronous reset mid-cycle during a stall.
    set_in(1'b1, 32'h3020, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    rand_data();
    @(negedge clk);
    set_in(1'b1, 32'h3024, 32'h2222_2222, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("pre_rst_cnt", b_cnt, 2'd2);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", a_valid, 1'b0);
    chk("arst_pc", a_pc, 32'h3000);
    chk("arst_instr", a_instr, 32'h0);
    chk("arst_data", a_data, 160'h0);
    chk("arst_cntA", a_cnt, 16'd0);
    chk("arst_cntB", b_cnt, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b1, 32'h3028, 32'h3333_3333, 1'b0, 1'b0, 1'b0);
    rand_data();
    @(negedge clk);
    chk("post_rst_pc", a_pc, 32'h3028);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
